// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment scan driver:
//   SEG_BLANK       - all segments off (active-low)
//   ANODE_OFF       - value of one anode bit when its digit is dark
//   SEG_HEX_0..F    - active-low segment patterns, bit 6 = a ... bit 0 = g
//   eff_len()       - clamps the programmed message length into a usable range
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic       ANODE_OFF = 1'b1;

    localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
    localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
    localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
    localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b1100000;
    localparam logic [6:0] SEG_HEX_C = 7'b0110001;
    localparam logic [6:0] SEG_HEX_D = 7'b1000010;
    localparam logic [6:0] SEG_HEX_E = 7'b0110000;
    localparam logic [6:0] SEG_HEX_F = 7'b0111000;

    // Zero or oversize lengths mean "whole buffer"; a message shorter than
    // the display is padded up so every lit digit maps to a distinct entry.
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned num_digits,
                                            input int unsigned msg_depth);
        if (len == 0 || len > msg_depth) return msg_depth;
        if (len < num_digits)            return num_digits;
        return len;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the character-source side (buffer writes, scroll control) and the
// display-pin side of the scan driver.
//   master: character source / board - drives wr_*, scroll_en, msg_len
//   slave : seg7_scan_driver         - drives an, seg, frame_tick, scroll_ptr
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16
);
    localparam int AW = $clog2(MSG_DEPTH);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [3:0]            wr_data;
    logic                  scroll_en;
    logic [AW:0]           msg_len;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  frame_tick;
    logic [AW-1:0]         scroll_ptr;

    modport master (
        output wr_en, wr_addr, wr_data, scroll_en, msg_len,
        input  an, seg, frame_tick, scroll_ptr
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, scroll_en, msg_len,
        output an, seg, frame_tick, scroll_ptr
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex digit to active-low 7-segment pattern.
//   i_hex : 4-bit character
//   o_seg : segments a..g, o_seg[6] = a ... o_seg[0] = g, active low
// ---------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            4'hF: o_seg = SEG_HEX_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed common-anode 7-segment driver with a hex character buffer
// and optional circular scrolling.
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus.wr_*   : buffer write port (address >= MSG_DEPTH ignored)
//   bus.scroll_en / bus.msg_len : scroll enable and message length
//   bus.an     : anodes, active low, an[NUM_DIGITS-1] = leftmost digit
//   bus.seg    : segments a..g, active low
//   bus.frame_tick : high on the last cycle of each frame
//   bus.scroll_ptr : buffer index shown on the leftmost digit
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int MSG_DEPTH     = 16,
    parameter int DIGIT_CYCLES  = 16,
    parameter int BLANK_CYCLES  = 2,
    parameter int SCROLL_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    seg7_scan_driver_if.slave bus
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int FW = $clog2(SCROLL_FRAMES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LIT  = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(SCROLL_FRAMES - 1);
    localparam logic [LW-1:0] DEPTH    = LW'(MSG_DEPTH);

    // r_cnt/r_dig describe the slot position currently on the pins; every
    // edge computes the following position and registers its outputs.
    logic [CW-1:0]                 r_cnt;
    logic [DW-1:0]                 r_dig;
    logic [FW-1:0]                 r_frm;
    logic [AW-1:0]                 r_ptr;
    logic [NUM_DIGITS-1:0]         r_an;
    logic [6:0]                    r_seg;
    logic                          r_tick;
    logic [MSG_DEPTH-1:0][3:0]     r_buf;

    logic [LW-1:0]         w_len;
    logic                  w_frame_end;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DW-1:0]         w_dig_nxt;
    logic [FW-1:0]         w_frm_nxt;
    logic [AW-1:0]         w_ptr_nxt;
    logic [LW-1:0]         w_idx;
    logic [3:0]            w_char;
    logic [6:0]            w_seg;
    logic                  w_lit_nxt;
    logic                  w_tick_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;

    assign w_len = LW'(eff_len(32'(bus.msg_len), NUM_DIGITS, MSG_DEPTH));

    // Slot / digit position sequencing
    always_comb begin
        w_frame_end = (r_cnt == CNT_LAST) && (r_dig == DIG_LAST);
        w_cnt_nxt   = r_cnt + 1'b1;
        w_dig_nxt   = r_dig;
        if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            w_dig_nxt = (r_dig == DIG_LAST) ? '0 : r_dig + 1'b1;
        end
        w_lit_nxt  = (w_cnt_nxt >= CNT_LIT);
        w_tick_nxt = (w_cnt_nxt == CNT_LAST) && (w_dig_nxt == DIG_LAST);
    end

    // Scroll pointer only moves on a frame boundary; an out-of-range pointer
    // (after msg_len shrank) is pulled back to 0 at the first boundary.
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_frm_nxt = bus.scroll_en ? r_frm : '0;
        if (w_frame_end) begin
            if (bus.scroll_en)
                w_frm_nxt = (r_frm == FRM_LAST) ? '0 : r_frm + 1'b1;
            if ({1'b0, r_ptr} >= w_len)
                w_ptr_nxt = '0;
            else if (bus.scroll_en && (r_frm == FRM_LAST))
                w_ptr_nxt = (({1'b0, r_ptr} + 1'b1) == w_len) ? '0 : r_ptr + 1'b1;
        end
    end

    // Character index: ptr + d < 2L when ptr is in range, so one subtract
    // wraps it; a stale pointer is saturated to the last valid entry.
    always_comb begin
        w_idx = {1'b0, w_ptr_nxt} + LW'(w_dig_nxt);
        if (w_idx >= w_len) w_idx = w_idx - w_len;
        if (w_idx >= w_len) w_idx = w_len - 1'b1;
        w_char = r_buf[w_idx[AW-1:0]];
    end

    seg7_hex_decode u_dec (
        .i_hex (w_char),
        .o_seg (w_seg)
    );

    always_comb begin
        w_an_nxt = {NUM_DIGITS{ANODE_OFF}};
        if (w_lit_nxt) w_an_nxt[DIG_LAST - w_dig_nxt] = ~ANODE_OFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf <= '0;
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH)) begin
            r_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_dig  <= '0;
            r_frm  <= '0;
            r_ptr  <= '0;
            r_an   <= {NUM_DIGITS{ANODE_OFF}};
            r_seg  <= SEG_BLANK;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_dig  <= w_dig_nxt;
            r_frm  <= w_frm_nxt;
            r_ptr  <= w_ptr_nxt;
            r_an   <= w_an_nxt;
            r_seg  <= w_lit_nxt ? w_seg : SEG_BLANK;
            r_tick <= w_tick_nxt;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_tick = r_tick;
    assign bus.scroll_ptr = r_ptr;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench: NUM_DIGITS=4, MSG_DEPTH=8, DIGIT_CYCLES=8, BLANK_CYCLES=2,
// SCROLL_FRAMES=2. Output cycle 0 is the interval between reset release and
// the first rising edge; cyc tracks the output cycle sampled at each falling
// edge. Frames are 32 cycles, scroll steps 64 cycles apart.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(4), .MSG_DEPTH(8)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS(4), .MSG_DEPTH(8), .DIGIT_CYCLES(8),
        .BLANK_CYCLES(2), .SCROLL_FRAMES(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S7 = 7'b0001111,
                           SA = 7'b0001000, SB = 7'b1100000, SD = 7'b1000010,
                           SE = 7'b0110000, SF = 7'b0111000, BL = 7'b1111111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    // Lit digit d expects anode bit 3-d low.
    task automatic chk_lit(input string tag, input int d, input logic [6:0] s);
        logic [3:0] a;
        a = 4'b1111;
        a[3-d] = 1'b0;
        chk({tag, "_an"}, bus.an, a);
        chk({tag, "_seg"}, bus.seg, s);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.scroll_en = 1'b0; bus.msg_len = '0;

        // Reset held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_an", bus.an, 4'b1111);
            chk("rst_seg", bus.seg, BL);
        end
        chk("rst_tick", bus.frame_tick, 1'b0);
        chk("rst_ptr", bus.scroll_ptr, 0);
        reset_n = 1'b1;
        cyc = 0;
        chk("c0_an", bus.an, 4'b1111);
        chk("c0_seg", bus.seg, BL);
        run_to(1);  chk("c1_seg", bus.seg, BL);
        run_to(2);  chk_lit("c2", 0, S0);
        run_to(7);  chk_lit("c7", 0, S0);
        run_to(8);  chk("c8_an", bus.an, 4'b1111);
        run_to(10); chk_lit("c10", 1, S0);

        // Static message 1,2,3,4
        run_to(11);
        wr(3'd0, 4'h1); wr(3'd1, 4'h2); wr(3'd2, 4'h3); wr(3'd3, 4'h4);
        run_to(30); chk("tick30", bus.frame_tick, 1'b0);
        run_to(31); chk("tick31", bus.frame_tick, 1'b1);
        run_to(32); chk("tick32", bus.frame_tick, 1'b0);
                    chk("f1_blank", bus.seg, BL);
        run_to(34); chk_lit("f1d0", 0, S1);
        run_to(40); chk("f1_gap_an", bus.an, 4'b1111);
        run_to(42); chk_lit("f1d1", 1, S2);
        run_to(50); chk_lit("f1d2", 2, S3);
        run_to(58); chk_lit("f1d3", 3, S4);
        run_to(63); chk("tick63", bus.frame_tick, 1'b1);
                    chk("ptr_static", bus.scroll_ptr, 0);

        // Write latency on a lit digit
        run_to(66); chk_lit("wl_pre", 0, S1);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'h7;
        tick();     bus.wr_en = 1'b0;
        chk("wl_old", bus.seg, S1);
        run_to(68); chk("wl_new", bus.seg, S7);

        // Scroll A..F with msg_len = 6
        run_to(96);
        wr(3'd0, 4'hA); wr(3'd1, 4'hB); wr(3'd2, 4'hC);
        wr(3'd3, 4'hD); wr(3'd4, 4'hE); wr(3'd5, 4'hF);
        bus.msg_len = 4'd6; bus.scroll_en = 1'b1;
        run_to(159); chk("sc_p0", bus.scroll_ptr, 0);
        run_to(160); chk("sc_p1", bus.scroll_ptr, 1);
        run_to(224); chk("sc_p2", bus.scroll_ptr, 2);
        run_to(288); chk("sc_p3", bus.scroll_ptr, 3);
        run_to(352); chk("sc_p4", bus.scroll_ptr, 4);
        run_to(354); chk_lit("p4d0", 0, SE);
        run_to(362); chk_lit("p4d1", 1, SF);
        run_to(370); chk_lit("p4d2", 2, SA);
        run_to(378); chk_lit("p4d3", 3, SB);
        run_to(416); chk("sc_p5", bus.scroll_ptr, 5);
        run_to(479); chk("sc_p5b", bus.scroll_ptr, 5);
        run_to(480); chk("sc_wrap6", bus.scroll_ptr, 0);

        // msg_len = 2 behaves as L = 4
        run_to(481); bus.msg_len = 4'd2;
        run_to(672); chk("l4_p3", bus.scroll_ptr, 3);
        run_to(674); chk_lit("l4d0", 0, SD);
        run_to(682); chk_lit("l4d1", 1, SA);
        run_to(736); chk("l4_wrap", bus.scroll_ptr, 0);

        // msg_len = 0 behaves as L = 8
        run_to(737); bus.msg_len = 4'd0;
        run_to(1184); chk("l0_p7", bus.scroll_ptr, 7);
        run_to(1186); chk_lit("l0d0", 0, S0);
        run_to(1194); chk_lit("l0d1", 1, SA);
        run_to(1248); chk("l0_wrap", bus.scroll_ptr, 0);

        // msg_len = 9 behaves as L = 8
        run_to(1249); bus.msg_len = 4'd9;
        run_to(1696); chk("l9_p7", bus.scroll_ptr, 7);

        // Shrink L below the pointer: indices saturate, pointer forced to 0
        run_to(1705); bus.msg_len = 4'd4;
        run_to(1708); chk_lit("shr_d1", 1, SD);
        run_to(1716); chk_lit("shr_d2", 2, SD);
        run_to(1727); chk("shr_hold", bus.scroll_ptr, 7);
        run_to(1728); chk("shr_force", bus.scroll_ptr, 0);

        // Pause at ptr=3 after one frame, then resume
        run_to(1761); bus.msg_len = 4'd6;
        run_to(1888); chk("pa_p3", bus.scroll_ptr, 3);
        run_to(1925); bus.scroll_en = 1'b0;
        run_to(1952); chk("pa_hold", bus.scroll_ptr, 3);
        run_to(1960); bus.scroll_en = 1'b1;
        run_to(1984); chk("pa_f1", bus.scroll_ptr, 3);
        run_to(2015); chk("pa_f2", bus.scroll_ptr, 3);
        run_to(2016); chk("pa_step", bus.scroll_ptr, 4);

        // Async reset in the middle of a lit slot
        run_to(2029); chk_lit("ar_pre", 1, SF);
        #1 reset_n = 1'b0;
        #1 chk("ar_an", bus.an, 4'b1111);
        chk("ar_seg", bus.seg, BL);
        for (int i = 0; i < 3; i++) @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        chk("ar_ptr", bus.scroll_ptr, 0);
        run_to(2);  chk_lit("ar_d0", 0, S0);
        run_to(10); chk_lit("ar_d1", 1, S0);
        run_to(18); chk_lit("ar_d2", 2, S0);
        run_to(26); chk_lit("ar_d3", 3, S0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
